data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 139 +++++++++++++
 tb/tb_data_mem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// In-order load/store responder: request FIFO feeding a word-addressed memory.
// Optional macro DMEM_STORE_ACK_EN: stores also return a response pulse.
module data_mem_responder #(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        rw_in,
  input  logic [3:0]  id_in,
  input  logic        valid_in,
  output logic [31:0] data_out,
  output logic [3:0]  id_out,
  output logic        ready_out,
  output logic        stall_out
);

  // state | meaning
  // IDLE  | nothing in service; pops the head when the FIFO is non-empty
  // WAIT  | request popped; its response is driven at the next edge
  // RESP  | ready_out high this cycle; may pop the next head
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MEM_WORDS);

`ifdef DMEM_STORE_ACK_EN
  localparam bit STORE_ACK = 1'b1;
`else
  localparam bit STORE_ACK = 1'b0;
`endif

  logic [IW-1:0] fifo_idx  [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic          fifo_rw   [DEPTH];
  logic [3:0]    fifo_id   [DEPTH];
  logic [31:0]   mem       [MEM_WORDS];

  state_t        state_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   svc_data_q, data_q;
  logic [3:0]    svc_id_q, id_q;
  logic          ready_q;

  logic          push, pop, pop_resp;
  logic [IW-1:0] req_idx, head_idx;
  logic [31:0]   head_data;
  logic          head_rw;
  logic [3:0]    head_id;
  logic          unused_addr;

  // Word index wraps modulo MEM_WORDS; byte offset is ignored.
  assign req_idx     = addr_in[IW+1:2];
  assign unused_addr = ^{addr_in[31:IW+2], addr_in[1:0]};

  assign stall_out = (count_q == CW'(DEPTH));
  assign push      = valid_in && !stall_out;
  assign pop       = (state_q != WAIT) && (count_q != '0);

  assign head_idx  = fifo_idx[rd_ptr_q];
  assign head_data = fifo_data[rd_ptr_q];
  assign head_rw   = fifo_rw[rd_ptr_q];
  assign head_id   = fifo_id[rd_ptr_q];

  // Stores without acknowledge retire silently at the pop edge.
  assign pop_resp  = pop && (!head_rw || STORE_ACK);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage is never reset; a store popped before reset stays written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr_q]  <= req_idx;
      fifo_data[wr_ptr_q] <= data_in;
      fifo_rw[wr_ptr_q]   <= rw_in;
      fifo_id[wr_ptr_q]   <= id_in;
    end
    if (pop && head_rw) begin
      mem[head_idx] <= head_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      svc_data_q <= '0;
      svc_id_q   <= '0;
      data_q     <= '0;
      id_q       <= '0;
      ready_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= 1'b0;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case (state_q)
        IDLE, RESP: begin
          if (pop) begin
            svc_id_q   <= head_id;
            svc_data_q <= head_rw ? head_data : mem[head_idx];
            state_q    <= pop_resp ? WAIT : IDLE;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          ready_q <= 1'b1;
          data_q  <= svc_data_q;
          id_q    <= svc_id_q;
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out  = data_q;
  assign id_out    = id_q;
  assign ready_out = ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expectations from a word-array model,
// compared by an independent monitor whenever ready_out is seen.
module tb_data_mem_responder;

`ifdef DMEM_STORE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_in, data_in;
  logic        rw_in;
  logic [3:0]  id_in;
  logic        valid_in;
  logic [31:0] data_out;
  logic [3:0]  id_out;
  logic        ready_out, stall_out;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(4), .MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in), .rw_in(rw_in),
    .id_in(id_in), .valid_in(valid_in), .data_out(data_out), .id_out(id_out),
    .ready_out(ready_out), .stall_out(stall_out)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] model_mem [int];
  int          vectors = 0, miscompares = 0;
  int          cyc = 0, acc_cyc = 0, last_resp_cyc = 0, resp_cnt = 0;
  bit          prev_ready = 1'b0, stall_seen = 1'b0, have_last = 1'b0;
  logic [31:0] last_data;
  logic [3:0]  last_id;

  always @(posedge clk) cyc++;

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(widx(a))) return model_mem[widx(a)];
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response must match the head of the expectation queue.
  always @(negedge clk) begin
    resp_t e;
    if (!rst) begin
      have_last = 1'b0;
    end else begin
      if (stall_out) stall_seen = 1'b1;
      if (ready_out) begin
        resp_cnt++;
        last_resp_cyc = cyc;
        check("ready_single_cycle", {31'b0, prev_ready}, 32'h0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got id %0d data %h expected no response", id_out, data_out);
        end else begin
          e = exp_q.pop_front();
          check("resp_id", {28'b0, id_out}, {28'b0, e.id});
          check("resp_data", data_out, e.data);
        end
        have_last = 1'b1;
        last_data = data_out;
        last_id   = id_out;
      end else if (have_last) begin
        check("hold_data", data_out, last_data);
        check("hold_id", {28'b0, id_out}, {28'b0, last_id});
      end
    end
    prev_ready = ready_out;
  end

  // Drive a request and hold it until accepted; update the model at acceptance.
  task automatic send(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] id);
    bit    stalled;
    int    waits = 0;
    resp_t e;
    rw_in = rw; addr_in = a; data_in = d; id_in = id; valid_in = 1'b1;
    forever begin
      stalled = stall_out;
      @(posedge clk);
      #1;
      if (!stalled) break;
      waits++;
      if (waits > 64) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: id %0d still stalled after %0d cycles, expected acceptance", id, waits);
        valid_in = 1'b0;
        return;
      end
    end
    acc_cyc = cyc;
    e.id = id;
    if (rw) begin
      model_mem[widx(a)] = d;
      e.data = d;
      if (ACK) exp_q.push_back(e);
    end else begin
      e.data = model_rd(a);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    valid_in = 1'b0;
    while (exp_q.size() > 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", exp_q.size(), 32'h0);
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r0, s_cyc, l_cyc;
    logic [31:0] a, b_old;
    logic [3:0]  w;
    rst = 1'b0; valid_in = 1'b0; rw_in = 1'b0; addr_in = '0; data_in = '0; id_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 32'h0);
    check("rst_id_out", {28'b0, id_out}, 32'h0);
    check("rst_ready_out", {31'b0, ready_out}, 32'h0);
    check("rst_stall_out", {31'b0, stall_out}, 32'h0);

    // Load from never-written word right after reset release.
    rst = 1'b1;
    r0 = resp_cnt;
    send(1'b0, 32'h10, 32'h0, 4'd3);
    drain();
    check("first_load_latency", last_resp_cyc - acc_cyc, 32'd2);
    check("first_load_count", resp_cnt - r0, 32'd1);

    // Store then dependent load, back to back.
    r0 = resp_cnt;
    send(1'b1, 32'h20, 32'hDEADBEEF, 4'd1);
    s_cyc = acc_cyc;
    send(1'b0, 32'h20, 32'h0, 4'd2);
    l_cyc = acc_cyc;
    drain();
    check("st_ld_accept_gap", l_cyc - s_cyc, 32'd1);
    check("st_ld_load_latency", last_resp_cyc - l_cyc, ACK ? 32'd3 : 32'd2);
    check("st_ld_resp_count", resp_cnt - r0, ACK ? 32'd2 : 32'd1);

    // Sustained back-to-back loads fill the FIFO and force a stall.
    stall_seen = 1'b0;
    r0 = resp_cnt;
    for (int i = 0; i < 8; i++) send(1'b0, 32'h20 + 32'(4 * (i % 3)), 32'h0, 4'(i));
    drain();
    check("burst_stall_seen", {31'b0, stall_seen}, 32'h1);
    check("burst_resp_count", resp_cnt - r0, 32'd8);

    // Random mix over a small word window, with some high-address aliases.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      w = 4'($urandom_range(0, 15));
      a = {20'h0, 6'h0, w, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 4) == 0) a = ($urandom() & 32'hFFFF_F000) | a;
      send(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)));
    end
    drain();

    // Reset while a load is in service with three requests queued.
    send(1'b1, 32'h40, 32'hA5A5_0001, 4'd9);
    send(1'b1, 32'h80, 32'h1234_5678, 4'd10);
    drain();
    b_old = model_rd(32'h80);
    send(1'b0, 32'h40, 32'h0, 4'd1);
    send(1'b0, 32'h40, 32'h0, 4'd2);
    send(1'b0, 32'h40, 32'h0, 4'd3);
    send(1'b0, 32'h80, 32'h0, 4'd4);
    send(1'b1, 32'h80, 32'hBAD0_BAD0, 4'd5);
    send(1'b0, 32'h40, 32'h0, 4'd6);
    valid_in = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_data_out", data_out, 32'h0);
    check("midrst_id_out", {28'b0, id_out}, 32'h0);
    check("midrst_ready_out", {31'b0, ready_out}, 32'h0);
    check("midrst_stall_out", {31'b0, stall_out}, 32'h0);
    exp_q.delete();
    model_mem[widx(32'h80)] = b_old;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    r0 = resp_cnt;
    idle(10);
    check("midrst_no_resp", resp_cnt - r0, 32'd0);
    send(1'b0, 32'h40, 32'h0, 4'd7);
    send(1'b0, 32'h80, 32'h0, 4'd8);
    drain();
    check("postrst_resp_count", resp_cnt - r0, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
